// File: rtl/arith_core_mod.sv
// arith_core_mod: 9-lane int8 conv MAC with channel accumulation, bias, ReLU, requantization and 4:1 max-pool
module arith_core_mod (
    input  logic        clk,
    input  logic        reset,
    input  logic [71:0] in,
    input  logic [71:0] weight,
    input  logic [15:0] bias,
    input  logic [1:0]  bound_level,
    input  logic [2:0]  step,
    input  logic        en,
    input  logic        en_relu,
    input  logic        en_mp,
    output logic [7:0]  out,
    output logic        out_en
);
    logic signed [15:0] prod [9];
    logic signed [23:0] p, acc, sh;
    logic signed [7:0]  q, q_r, mx, mx_n;
    logic [2:0] cnt;
    logic [1:0] pcnt;
    logic acc_v, q_v, last;

    for (genvar k = 0; k < 9; k++) begin : g_lane
        assign prod[k] = $signed(in[8*(8-k) +: 8]) * $signed(weight[8*(8-k) +: 8]);
    end

    always_comb begin
        p = '0;
        for (int i = 0; i < 9; i++) p = p + 24'(prod[i]);
    end

    assign sh   = acc >>> {bound_level, 2'b00};
    assign q    = (en_relu && sh < 0) ? 8'sd0 : (sh > 24'sd127) ? 8'sd127 : (sh < -24'sd128) ? 8'h80 : sh[7:0];
    assign last = !en_mp || pcnt == 2'd3;
    // without pooling pcnt stays 0, so mx_n is simply the current result
    assign mx_n = (pcnt == 2'd0 || q_r > mx) ? q_r : mx;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            cnt    <= '0;
            acc_v  <= 1'b0;
            q_r    <= '0;
            q_v    <= 1'b0;
            mx     <= '0;
            pcnt   <= '0;
            out    <= '0;
            out_en <= 1'b0;
        end else begin
            if (en) begin
                acc <= (cnt == 3'd0) ? p + 24'($signed(bias)) : acc + p;
                cnt <= (cnt == step) ? 3'd0 : cnt + 3'd1;
            end
            acc_v  <= en && cnt == step;
            q_v    <= acc_v;
            out_en <= q_v && last;
            if (acc_v) q_r <= q;
            if (q_v) begin
                mx   <= mx_n;
                pcnt <= en_mp ? pcnt + 2'd1 : 2'd0;
                if (last) out <= mx_n;
            end
        end
    end
endmodule

// File: tb/tb_arith_core_mod.sv
// tb_arith_core_mod: table, directed and randomized checks of arith_core_mod against a behavioural model
module tb_arith_core_mod;
    logic clk = 1'b0, reset = 1'b1, en = 1'b0, en_relu = 1'b0, en_mp = 1'b0;
    logic [71:0] in_v = '0, weight_v = '0;
    logic [15:0] bias_v = '0;
    logic [1:0] bound_v = '0;
    logic [2:0] step_v = '0;
    logic [7:0] out;
    logic out_en;
    int cyc = 0, n_cmp = 0, n_bad = 0;
    int m_acc = 0, m_n = 0;
    int m_pool[$];

    typedef struct { int val; int cyc; } ev_t;
    ev_t got_q[$], exp_q[$];

    typedef struct {
        logic [71:0] a;
        logic [71:0] w;
        logic [15:0] b;
        logic [1:0]  bd;
        logic        relu;
        logic [7:0]  y;
    } vec_t;
    vec_t tbl[9];

    arith_core_mod dut (
        .clk(clk), .reset(reset), .in(in_v), .weight(weight_v), .bias(bias_v),
        .bound_level(bound_v), .step(step_v), .en(en), .en_relu(en_relu), .en_mp(en_mp),
        .out(out), .out_en(out_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (out_en) got_q.push_back('{int'($signed(out)), cyc});

    function automatic logic [71:0] rep(input logic [7:0] v);
        return {9{v}};
    endfunction

    function automatic logic [71:0] mk(input int s);
        return {8'(s), 64'd0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // reference: counts windows, keeps the running sum, collects pooled results in a list
    function automatic void model_win(input logic [71:0] a, input logic [71:0] w, input int c);
        int s = 0;
        int t, mx;
        for (int k = 0; k < 9; k++) s += int'($signed(a[8*k +: 8])) * int'($signed(w[8*k +: 8]));
        m_acc = (m_n == 0) ? s + int'($signed(bias_v)) : m_acc + s;
        m_n = m_n + 1;
        if (m_n <= int'(step_v)) return;
        m_n = 0;
        t = m_acc >>> (4 * int'(bound_v));
        if (t > 127) t = 127;
        if (t < -128) t = -128;
        if (en_relu && t < 0) t = 0;
        if (!en_mp) begin
            exp_q.push_back('{t, c + 3});
            return;
        end
        m_pool.push_back(t);
        if (m_pool.size() == 4) begin
            mx = m_pool[0];
            foreach (m_pool[i]) if (m_pool[i] > mx) mx = m_pool[i];
            exp_q.push_back('{mx, c + 3});
            m_pool.delete();
        end
    endfunction

    task automatic win(input logic [71:0] a, input logic [71:0] w);
        in_v = a;
        weight_v = w;
        en = 1'b1;
        model_win(a, w, cyc);
        tick();
        en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        chk("rst_out", int'(out), 0);
        chk("rst_out_en", int'(out_en), 0);
        reset = 1'b0;
        m_acc = 0;
        m_n = 0;
        m_pool.delete();
    endtask

    task automatic cfg(input logic [15:0] b, input logic [1:0] bd, input logic [2:0] st, input logic r, input logic m);
        bias_v = b;
        bound_v = bd;
        step_v = st;
        en_relu = r;
        en_mp = m;
        do_reset();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_q(input string nm);
        chk({nm, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk({nm, "_val"}, got_q[i].val, exp_q[i].val);
            chk({nm, "_cyc"}, got_q[i].cyc, exp_q[i].cyc);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [71:0] a, w;
        int d;
        int sums[8];
        tbl[0] = '{rep(8'd1),   rep(8'd1),   16'd0,      2'd0, 1'b0, 8'd9};
        tbl[1] = '{rep(8'd1),   rep(8'hFF),  16'd0,      2'd0, 1'b0, 8'hF7};
        tbl[2] = '{rep(8'd1),   rep(8'hFF),  16'd0,      2'd0, 1'b1, 8'h00};
        tbl[3] = '{rep(8'd127), rep(8'd127), 16'd0,      2'd0, 1'b0, 8'd127};
        tbl[4] = '{rep(8'd127), rep(8'd127), 16'd0,      2'd3, 1'b0, 8'd35};
        tbl[5] = '{rep(8'd127), rep(8'h80),  16'd0,      2'd0, 1'b0, 8'h80};
        tbl[6] = '{rep(8'd1),   rep(8'hFF),  16'd0,      2'd1, 1'b0, 8'hFF};
        tbl[7] = '{rep(8'd1),   rep(8'd1),   16'hFFEC,   2'd0, 1'b0, 8'hF5};
        tbl[8] = '{rep(8'd1),   rep(8'd1),   16'd300,    2'd1, 1'b0, 8'd19};
        tick();
        chk("init_out", int'(out), 0);
        chk("init_out_en", int'(out_en), 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            cfg(tbl[i].b, tbl[i].bd, 3'd0, tbl[i].relu, 1'b0);
            d = cyc;
            win(tbl[i].a, tbl[i].w);
            idle(5);
            chk("tbl_count", got_q.size(), 1);
            if (got_q.size() > 0) begin
                chk("tbl_val", got_q[0].val, int'($signed(tbl[i].y)));
                chk("tbl_cyc", got_q[0].cyc, d + 3);
            end
            chk("tbl_hold", int'(out), int'(tbl[i].y));
            got_q.delete();
            exp_q.delete();
        end

        cfg(16'd0, 2'd0, 3'd0, 1'b0, 1'b0);
        d = cyc;
        repeat (64) win(rep(8'd1), rep(8'd1));
        idle(5);
        chk("stream_count", got_q.size(), 64);
        if (got_q.size() > 0) chk("stream_first_cyc", got_q[0].cyc, d + 3);
        check_q("stream");

        cfg(16'd4, 2'd0, 3'd3, 1'b0, 1'b0);
        repeat (4) win(rep(8'd1), rep(8'd1));
        idle(5);
        chk("acc4_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("acc4_val", got_q[0].val, 40);
        check_q("acc4");

        cfg(16'd4, 2'd0, 3'd3, 1'b0, 1'b0);
        repeat (4) begin
            win(rep(8'd1), rep(8'd1));
            idle(2);
        end
        idle(5);
        if (got_q.size() > 0) chk("acc4_gap_val", got_q[0].val, 40);
        check_q("acc4_gap");

        cfg(16'd0, 2'd0, 3'd0, 1'b0, 1'b1);
        sums = '{1, 5, -3, 2, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) win(mk(sums[i]), mk(1));
        idle(5);
        chk("pool_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("pool_val", got_q[0].val, 5);
        check_q("pool");

        cfg(16'd0, 2'd0, 3'd0, 1'b1, 1'b1);
        sums = '{-4, -2, -7, -1, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) win(mk(sums[i]), mk(1));
        idle(5);
        if (got_q.size() > 0) chk("pool_relu_val", got_q[0].val, 0);
        check_q("pool_relu");

        cfg(16'd0, 2'd0, 3'd1, 1'b0, 1'b1);
        repeat (3) win(mk(50), mk(1));
        do_reset();
        idle(6);
        chk("rst_drop_count", got_q.size(), 0);
        exp_q.delete();
        got_q.delete();
        sums = '{3, -1, 7, 2, -5, 4, 0, 6};
        for (int i = 0; i < 8; i++) win(mk(sums[i]), mk(1));
        idle(5);
        chk("restart_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("restart_val", got_q[0].val, 9);
        check_q("restart");

        for (int r = 0; r < 8; r++) begin
            cfg(16'(int'($urandom_range(0, 400)) - 200), 2'($urandom_range(0, 3)),
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 64; i++) begin
                for (int k = 0; k < 9; k++) begin
                    a[8*k +: 8] = (r % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'(int'($urandom_range(0, 15)) - 8);
                    w[8*k +: 8] = (r % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'(int'($urandom_range(0, 15)) - 8);
                end
                win(a, w);
                idle($urandom_range(0, 2));
            end
            idle(5);
            check_q("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
